// File: rtl/exception_ctrl.sv
// Multi-source exception controller: per-source pending latches, masking, fixed-priority
// arbitration and a REDIRECT/HANDLER state machine. Define EXC_VECTORED_EN for per-source vectors.
module exception_ctrl #(
    parameter int             N       = 64,
    parameter int             NSRC    = 4,
    parameter logic [N-1:0]   VBASE   = N'(64'hD8),
    parameter logic [N-1:0]   VSTRIDE = N'(64'h20)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   exc_req,
    input  logic [NSRC-1:0]   exc_mask,
    input  logic [N-1:0]      NextPC_F,
    input  logic [N-1:0]      imem_addr_F,
    input  logic [N-1:0]      PCBranch_EX,
    input  logic              ERet,
    input  logic [1:0]        IM_readData,
    output logic              EProc,
    output logic              ExcAck,
    output logic              in_handler,
    output logic [N-1:0]      ExcVector,
    output logic [N-1:0]      readData3_E,
    output logic [N-1:0]      PCBranch_EXP
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_HANDLER  = 2'd2;

`ifdef EXC_VECTORED_EN
    localparam logic [N-1:0] STRIDE_EFF = VSTRIDE;
`else
    // Shared entry: stride collapses to zero so every source lands on VBASE.
    localparam logic [N-1:0] STRIDE_EFF = VSTRIDE & {N{1'b0}};
`endif

    logic [1:0]      state_r;
    logic [NSRC-1:0] pend_r;
    logic [N-1:0]    err_r;
    logic [N-1:0]    elr_r;
    logic [3:0]      esr_r;

    logic [NSRC-1:0] elig_s;
    logic [NSRC-1:0] clr_s;
    logic [3:0]      win_idx_s;
    logic            any_req_s;
    logic            take_s;
    logic [N-1:0]    vector_s;
    logic            ack_s;

    // Fixed-priority arbiter: scan high to low so the lowest eligible index ends up winning.
    always_comb begin
        elig_s    = pend_r & ~exc_mask;
        win_idx_s = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            win_idx_s = elig_s[i] ? 4'(i) : win_idx_s;
        end
        any_req_s = |elig_s;
        take_s    = (state_r == ST_IDLE) && any_req_s;
        clr_s     = take_s ? (NSRC'(1'b1) << win_idx_s) : {NSRC{1'b0}};
    end

    assign vector_s = VBASE + (N'(esr_r) * STRIDE_EFF);
    assign ack_s    = (state_r == ST_REDIRECT) && (imem_addr_F == vector_s);

    // Pending latches; a request on the capture edge re-arms the bit (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= {NSRC{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_s) | exc_req;
        end
    end

    // Handler state machine and return-state capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            err_r   <= {N{1'b0}};
            elr_r   <= {N{1'b0}};
            esr_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        elr_r   <= imem_addr_F;
                        err_r   <= NextPC_F;
                        esr_r   <= win_idx_s;
                        state_r <= ST_REDIRECT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REDIRECT: state_r <= ack_s ? ST_HANDLER : ST_REDIRECT;
                ST_HANDLER:  state_r <= ERet ? ST_IDLE : ST_HANDLER;
                default:     state_r <= ST_IDLE;
            endcase
        end
    end

    // Readback mux for handler software.
    always_comb begin
        case (IM_readData)
            2'd0:    readData3_E = err_r;
            2'd1:    readData3_E = elr_r;
            2'd2:    readData3_E = N'(esr_r);
            2'd3:    readData3_E = N'(pend_r);
            default: readData3_E = err_r;
        endcase
    end

    assign EProc        = (state_r == ST_REDIRECT);
    assign ExcAck       = ack_s;
    assign in_handler   = (state_r == ST_HANDLER);
    assign ExcVector    = vector_s;
    assign PCBranch_EXP = ERet ? err_r : PCBranch_EX;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed requests push expected captures; a negedge
// monitor pops and checks them whenever EProc rises. Inline checks cover the rest.
module tb_exception_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  exc_req;
    logic [3:0]  exc_mask;
    logic [63:0] NextPC_F;
    logic [63:0] imem_addr_F;
    logic [63:0] PCBranch_EX;
    logic        ERet;
    logic [1:0]  IM_readData;
    logic        EProc;
    logic        ExcAck;
    logic        in_handler;
    logic [63:0] ExcVector;
    logic [63:0] readData3_E;
    logic [63:0] PCBranch_EXP;

    typedef struct {
        logic [3:0]  esr;
        logic [63:0] vec;
    } cap_t;

    cap_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    exception_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .exc_mask     (exc_mask),
        .NextPC_F     (NextPC_F),
        .imem_addr_F  (imem_addr_F),
        .PCBranch_EX  (PCBranch_EX),
        .ERet         (ERet),
        .IM_readData  (IM_readData),
        .EProc        (EProc),
        .ExcAck       (ExcAck),
        .in_handler   (in_handler),
        .ExcVector    (ExcVector),
        .readData3_E  (readData3_E),
        .PCBranch_EXP (PCBranch_EXP)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [63:0] vec(input logic [3:0] esr);
`ifdef EXC_VECTORED_EN
        return 64'hD8 + 64'(esr) * 64'h20;
`else
        return 64'hD8 + (64'(esr) & 64'h0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rb(input logic [1:0] sel, input logic [63:0] exp, input string nm);
        IM_readData = sel;
        #1;
        chk(nm, readData3_E, exp);
        IM_readData = 2'd2;
    endtask

    task automatic expect_cap(input logic [3:0] esr);
        cap_t c;
        c.esr = esr;
        c.vec = vec(esr);
        sb_q.push_back(c);
    endtask

    // Drive fetch onto the vector, enter the handler, then return with ERet.
    task automatic finish_handler(input logic [3:0] esr);
        imem_addr_F = vec(esr);
        #1;
        chk("fh_ack", ExcAck, 64'd1);
        step();
        chk("fh_in_handler", in_handler, 64'd1);
        ERet = 1'b1;
        step();
        ERet        = 1'b0;
        imem_addr_F = 64'h0;
    endtask

    // Monitor: every EProc rising edge must match the oldest expected capture.
    initial begin
        logic eproc_q;
        eproc_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                eproc_q = 1'b0;
            end else begin
                if (EProc && !eproc_q) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_unexpected_capture: got EProc=1 esr=%0d, required no capture", readData3_E);
                    end else begin
                        cap_t e;
                        e = sb_q.pop_front();
                        chk("sb_esr", readData3_E, 64'(e.esr));
                        chk("sb_vector", ExcVector, e.vec);
                    end
                end
                eproc_q = EProc;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        exc_req     = 4'b0000;
        exc_mask    = 4'b0000;
        NextPC_F    = 64'h0;
        imem_addr_F = 64'h0;
        PCBranch_EX = 64'h0;
        ERet        = 1'b0;
        IM_readData = 2'd0;
        repeat (3) step();

        // Reset values
        chk("rst_eproc", EProc, 64'd0);
        chk("rst_ack", ExcAck, 64'd0);
        chk("rst_in_handler", in_handler, 64'd0);
        chk("rst_vector", ExcVector, 64'hD8);
        rb(2'd0, 64'h0, "rst_err");
        rb(2'd3, 64'h0, "rst_pend");
        reset = 1'b0;
        step();

        // Single source 2, two-cycle latency and capture contents
        exc_req     = 4'b0100;
        imem_addr_F = 64'h40;
        NextPC_F    = 64'h44;
        expect_cap(4'd2);
        step();
        exc_req = 4'b0000;
        chk("t1_eproc_early", EProc, 64'd0);
        rb(2'd3, 64'h4, "t1_pend_set");
        step();
        chk("t1_eproc", EProc, 64'd1);
        chk("t1_noack", ExcAck, 64'd0);
        chk("t1_vector", ExcVector, vec(4'd2));
        rb(2'd1, 64'h40, "t1_elr");
        rb(2'd0, 64'h44, "t1_err");
        rb(2'd2, 64'h2, "t1_esr");
        step();
        chk("t1_eproc_hold", EProc, 64'd1);
        imem_addr_F = vec(4'd2);
        #1;
        chk("t1_ack", ExcAck, 64'd1);
        step();
        chk("t1_in_handler", in_handler, 64'd1);
        chk("t1_eproc_low", EProc, 64'd0);
        chk("t1_ack_low", ExcAck, 64'd0);
        imem_addr_F = 64'h0;
        PCBranch_EX = 64'h900;
        ERet        = 1'b1;
        #1;
        chk("t1_eret_pc", PCBranch_EXP, 64'h44);
        step();
        ERet = 1'b0;
        #1;
        chk("t1_idle", in_handler, 64'd0);
        chk("t1_branch_pc", PCBranch_EXP, 64'h900);
        ERet = 1'b1;
        #1;
        chk("t1_idle_eret_pc", PCBranch_EXP, 64'h44);
        step();
        chk("t1_idle_eret_state", in_handler, 64'd0);
        chk("t1_idle_eret_eproc", EProc, 64'd0);
        ERet = 1'b0;

        // Priority: sources 1 and 3 together
        exc_req     = 4'b1010;
        imem_addr_F = 64'h100;
        NextPC_F    = 64'h104;
        expect_cap(4'd1);
        expect_cap(4'd3);
        step();
        exc_req = 4'b0000;
        step();
        chk("t2_eproc", EProc, 64'd1);
        rb(2'd3, 64'h8, "t2_pend");
        rb(2'd2, 64'h1, "t2_esr");
        finish_handler(4'd1);
        imem_addr_F = 64'h200;
        NextPC_F    = 64'h204;
        #1;
        chk("t2_gap_eproc", EProc, 64'd0);
        chk("t2_gap_handler", in_handler, 64'd0);
        step();
        chk("t2_second_eproc", EProc, 64'd1);
        rb(2'd2, 64'h3, "t2_second_esr");
        rb(2'd1, 64'h200, "t2_second_elr");
        rb(2'd3, 64'h0, "t2_pend_empty");
        finish_handler(4'd3);

        // Mask holds source 0 pending until released
        exc_mask = 4'b0001;
        exc_req  = 4'b0001;
        step();
        exc_req = 4'b0000;
        chk("t3_masked_a", EProc, 64'd0);
        step();
        chk("t3_masked_b", EProc, 64'd0);
        rb(2'd3, 64'h1, "t3_pend_held");
        expect_cap(4'd0);
        exc_mask    = 4'b0000;
        imem_addr_F = 64'h300;
        step();
        chk("t3_unmasked_eproc", EProc, 64'd1);
        rb(2'd3, 64'h0, "t3_pend_clr");
        rb(2'd1, 64'h300, "t3_elr");
        finish_handler(4'd0);

        // Set/clear collision on the capture edge
        exc_req = 4'b0100;
        expect_cap(4'd2);
        expect_cap(4'd2);
        step();
        step();
        exc_req = 4'b0000;
        chk("t4_eproc", EProc, 64'd1);
        rb(2'd3, 64'h4, "t4_pend_kept");
        finish_handler(4'd2);
        step();
        chk("t4_retake_eproc", EProc, 64'd1);
        rb(2'd3, 64'h0, "t4_pend_final");
        finish_handler(4'd2);

        // Asynchronous reset while in the handler with source 1 still pending
        exc_req     = 4'b0011;
        imem_addr_F = 64'h500;
        expect_cap(4'd0);
        step();
        exc_req = 4'b0000;
        step();
        chk("t5_eproc", EProc, 64'd1);
        imem_addr_F = vec(4'd0);
        step();
        chk("t5_in_handler", in_handler, 64'd1);
        rb(2'd3, 64'h2, "t5_pend_before");
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_handler", in_handler, 64'd0);
        chk("t5_rst_eproc", EProc, 64'd0);
        chk("t5_rst_ack", ExcAck, 64'd0);
        chk("t5_rst_vector", ExcVector, 64'hD8);
        rb(2'd3, 64'h0, "t5_rst_pend");
        rb(2'd0, 64'h0, "t5_rst_err");
        imem_addr_F = 64'h0;
        step();
        reset = 1'b0;
        imem_addr_F = 64'h600;
        exc_req     = 4'b1000;
        expect_cap(4'd3);
        step();
        exc_req = 4'b0000;
        step();
        chk("t5_post_eproc", EProc, 64'd1);
        rb(2'd1, 64'h600, "t5_post_elr");
        finish_handler(4'd3);

        repeat (3) step();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        chk("end_idle", EProc, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
